// File: rtl/pcie_prog_loader.sv
// Loads a DRAM program from the PCIe transaction buffer into instruction memory,
// then sequences the armed -> execute -> armed cycle of that program.
module pcie_prog_loader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_WIDTH-1:0]   in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic [DATA_WIDTH/2-1:0] in_upper_half_data,
  input  logic                    in_upper_half_valid,
  output logic                    in_upper_half_ready,
  input  logic                    in_programmed_stop,
  input  logic                    load_start,
  input  logic                    load_abort,
  input  logic                    exec_go,
  output logic                    exec_start,
  input  logic                    exec_done,
  output logic                    imem_we,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_wdata,
  output logic [1:0]              imem_wmask,
  output logic [ADDR_WIDTH:0]     prog_len,
  output logic                    prog_valid,
  output logic                    busy,
  output logic                    overflow_err
);

  localparam int unsigned HW    = DATA_WIDTH / 2;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned CAP   = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TAIL, S_ARMED, S_EXEC, S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic [CNT_W-1:0]        prog_len_q, prog_len_d;
  logic                    in_tready_q, in_tready_d;
  logic                    half_ready_q, half_ready_d;
  logic                    exec_start_q, exec_start_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
  logic [1:0]              imem_wmask_q, imem_wmask_d;
  logic                    prog_valid_q, prog_valid_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;
  logic                    full_fire, half_fire, cnt_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      prog_len_q   <= '0;
      in_tready_q  <= 1'b0;
      half_ready_q <= 1'b0;
      exec_start_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_wmask_q <= '0;
      prog_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      prog_len_q   <= prog_len_d;
      in_tready_q  <= in_tready_d;
      half_ready_q <= half_ready_d;
      exec_start_q <= exec_start_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_wmask_q <= imem_wmask_d;
      prog_valid_q <= prog_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Readies and status flags are computed from the next state so they are valid in-state.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    prog_len_d   = prog_len_q;
    overflow_d   = overflow_q;
    exec_start_d = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    imem_wmask_d = imem_wmask_q;

    full_fire = (state_q == S_LOAD) && in_tvalid && in_tready_q;
    half_fire = (state_q == S_TAIL) && in_upper_half_valid && half_ready_q;
    cnt_full  = (wcnt_q == CNT_W'(CAP));

    // A handshake always produces its write, even if an abort arrives the same cycle.
    if (full_fire) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
      imem_wdata_d = in_tdata;
      imem_wmask_d = 2'b11;
      wcnt_d       = wcnt_q + CNT_W'(1);
    end else if (half_fire) begin
      imem_we_d    = 1'b1;
      imem_addr_d  = wcnt_q[ADDR_WIDTH-1:0];
      imem_wdata_d = {in_upper_half_data, HW'(0)};
      imem_wmask_d = 2'b10;
      wcnt_d       = wcnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (load_start && !load_abort) begin
          state_d    = S_LOAD;
          wcnt_d     = '0;
          overflow_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (cnt_full && (in_tvalid || in_upper_half_valid)) begin
          state_d    = S_ERR;
          overflow_d = 1'b1;
        end else if (!in_tvalid && in_programmed_stop) begin
          if (in_upper_half_valid) begin
            state_d = S_TAIL;
          end else begin
            state_d    = S_ARMED;
            prog_len_d = wcnt_q;
          end
        end
      end
      S_TAIL: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_ARMED;
          prog_len_d = wcnt_d;
        end
      end
      S_ARMED: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (load_start) begin
          state_d    = S_LOAD;
          wcnt_d     = '0;
          overflow_d = 1'b0;
        end else if (exec_go) begin
          state_d      = S_EXEC;
          exec_start_d = 1'b1;
        end
      end
      S_EXEC: begin
        if (exec_done) state_d = S_ARMED;
      end
      S_ERR: begin
        if (load_abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_tready_d  = (state_d == S_LOAD) && (wcnt_d < CNT_W'(CAP));
    half_ready_d = (state_d == S_TAIL);
    prog_valid_d = (state_d == S_ARMED) || (state_d == S_EXEC);
    busy_d       = (state_d == S_LOAD) || (state_d == S_TAIL) || (state_d == S_EXEC);
  end

  assign in_tready           = in_tready_q;
  assign in_upper_half_ready = half_ready_q;
  assign exec_start          = exec_start_q;
  assign imem_we             = imem_we_q;
  assign imem_addr           = imem_addr_q;
  assign imem_wdata          = imem_wdata_q;
  assign imem_wmask          = imem_wmask_q;
  assign prog_len            = prog_len_q;
  assign prog_valid          = prog_valid_q;
  assign busy                = busy_q;
  assign overflow_err        = overflow_q;

endmodule

// File: tb/tb_pcie_prog_loader.sv
// Scoreboard bench for pcie_prog_loader: drivers push expected memory writes and
// exec pulses into queues; a monitor pops and compares whenever the DUT emits them.
module tb_pcie_prog_loader;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 3;
  localparam int unsigned CAP = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   in_tdata;
  logic            in_tvalid;
  logic            in_tready;
  logic [DW/2-1:0] in_upper_half_data;
  logic            in_upper_half_valid;
  logic            in_upper_half_ready;
  logic            in_programmed_stop;
  logic            load_start, load_abort, exec_go, exec_done;
  logic            exec_start;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [DW-1:0]   imem_wdata;
  logic [1:0]      imem_wmask;
  logic [AW:0]     prog_len;
  logic            prog_valid, busy, overflow_err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    mask;
  } wr_t;

  wr_t  exp_q[$];
  int   exp_exec[$];
  int   checks = 0;
  int   failures = 0;
  int   m_cnt = 0;
  logic prev_es = 1'b0;

  pcie_prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(rst_n),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_upper_half_data(in_upper_half_data), .in_upper_half_valid(in_upper_half_valid),
    .in_upper_half_ready(in_upper_half_ready), .in_programmed_stop(in_programmed_stop),
    .load_start(load_start), .load_abort(load_abort), .exec_go(exec_go),
    .exec_start(exec_start), .exec_done(exec_done),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_wmask(imem_wmask),
    .prog_len(prog_len), .prog_valid(prog_valid), .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe and exec pulse must match the next expected entry.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(imem_addr), 64'hFFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 64'(imem_addr), 64'(w.addr));
          chk("wr_data", imem_wdata, w.data);
          chk("wr_mask", 64'(imem_wmask), 64'(w.mask));
        end
      end
      if (exec_start) begin
        if (prev_es) chk("exec_start_width", 64'(2), 64'(1));
        else if (exp_exec.size() == 0) chk("unexpected_exec_start", 64'(1), 64'(0));
        else chk("exec_start_tag", 64'(exp_exec.pop_front()), 64'(1));
      end
      prev_es = exec_start;
    end
  end

  task automatic start_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    m_cnt = 0;
  endtask

  task automatic abort();
    @(negedge clk); load_abort = 1'b1;
    @(negedge clk); load_abort = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    wr_t w;
    int  t;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    w.addr = AW'(m_cnt); w.data = d; w.mask = 2'b11;
    exp_q.push_back(w);
    m_cnt++;
    in_tdata = d; in_tvalid = 1'b1; t = 0;
    while (!in_tready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("tready_timeout", 64'(0), 64'(1));
    @(negedge clk); in_tvalid = 1'b0;
  endtask

  task automatic finish_load(input bit with_half, input logic [DW/2-1:0] h);
    wr_t w;
    int  t;
    in_programmed_stop = 1'b1;
    if (with_half) begin
      in_upper_half_valid = 1'b1; in_upper_half_data = h;
      w.addr = AW'(m_cnt); w.data = {h, 32'h0}; w.mask = 2'b10;
      exp_q.push_back(w);
      m_cnt++;
      t = 0;
      @(negedge clk);
      while (!in_upper_half_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("half_ready_timeout", 64'(0), 64'(1));
      @(negedge clk);
      in_upper_half_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    in_programmed_stop = 1'b0;
    @(negedge clk);
    chk("armed_prog_valid", 64'(prog_valid), 64'(1));
    chk("armed_prog_len", 64'(prog_len), 64'(m_cnt));
    chk("armed_busy", 64'(busy), 64'(0));
    chk("armed_tready", 64'(in_tready), 64'(0));
  endtask

  task automatic do_exec();
    int unsigned len0;
    len0 = prog_len;
    @(negedge clk); exec_go = 1'b1; exp_exec.push_back(1);
    @(negedge clk); exec_go = 1'b0;
    chk("exec_busy", 64'(busy), 64'(1));
    // exec_go and load_start during execution must be ignored
    @(negedge clk); exec_go = 1'b1; load_start = 1'b1;
    @(negedge clk); exec_go = 1'b0; load_start = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("exec_still_busy", 64'(busy), 64'(1));
    exec_done = 1'b1;
    @(negedge clk); exec_done = 1'b0;
    chk("post_exec_prog_valid", 64'(prog_valid), 64'(1));
    chk("post_exec_busy", 64'(busy), 64'(0));
    chk("post_exec_prog_len", 64'(prog_len), 64'(len0));
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_tdata = '0; in_tvalid = 0; in_upper_half_data = '0; in_upper_half_valid = 0;
    in_programmed_stop = 0; load_start = 0; load_abort = 0; exec_go = 0; exec_done = 0;
    #12;
    chk("reset_outputs", 64'(|{in_tready, in_upper_half_ready, exec_start, imem_we, imem_addr,
        imem_wdata, imem_wmask, prog_len, prog_valid, busy, overflow_err}), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // 3 full words then stop
    start_load();
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_prog_valid", 64'(prog_valid), 64'(0));
    for (int i = 0; i < 3; i++) send_word(rnd64());
    finish_load(1'b0, '0);

    // reload from ARMED: 2 words + lone upper half
    start_load();
    send_word(64'h1111_2222_3333_4444);
    send_word(64'h5555_6666_7777_8888);
    finish_load(1'b1, 32'hA5A5A5A5);
    do_exec();

    // load_start beats exec_go in ARMED
    @(negedge clk); load_start = 1'b1; exec_go = 1'b1;
    @(negedge clk); load_start = 1'b0; exec_go = 1'b0; m_cnt = 0;
    chk("ls_wins_busy", 64'(busy), 64'(1));
    chk("ls_wins_prog_valid", 64'(prog_valid), 64'(0));
    send_word(rnd64());
    finish_load(1'b0, '0);
    abort();
    chk("abort_armed_prog_valid", 64'(prog_valid), 64'(0));
    chk("abort_armed_busy", 64'(busy), 64'(0));

    // overflow: capacity words then one more offered
    start_load();
    for (int i = 0; i < int'(CAP); i++) send_word(rnd64());
    in_tdata = rnd64(); in_tvalid = 1'b1;
    @(negedge clk);
    @(negedge clk); in_tvalid = 1'b0;
    chk("ovf_err", 64'(overflow_err), 64'(1));
    chk("ovf_tready", 64'(in_tready), 64'(0));
    chk("ovf_busy", 64'(busy), 64'(0));
    chk("ovf_prog_valid", 64'(prog_valid), 64'(0));
    abort();
    chk("ovf_sticky_after_abort", 64'(overflow_err), 64'(1));
    start_load();
    chk("ovf_cleared_on_load", 64'(overflow_err), 64'(0));
    abort();

    // random loads, optional half, optional exec
    for (int it = 0; it < 8; it++) begin
      int  n;
      bit  hv;
      n  = $urandom_range(0, CAP);
      hv = (n < int'(CAP)) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_load();
      for (int i = 0; i < n; i++) send_word(rnd64());
      finish_load(hv, $urandom());
      if ($urandom_range(0, 1) == 1) do_exec();
    end

    // asynchronous reset in the middle of a load
    start_load();
    send_word(rnd64());
    send_word(rnd64());
    @(negedge clk); @(negedge clk);
    chk("pre_reset_queue_empty", 64'(exp_q.size()), 64'(0));
    in_tdata = rnd64(); in_tvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midload_reset_outputs", 64'(|{in_tready, in_upper_half_ready, exec_start, imem_we,
        imem_addr, imem_wdata, imem_wmask, prog_len, prog_valid, busy, overflow_err}), 64'(0));
    in_tvalid = 1'b0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    start_load();
    send_word(64'hDEAD_BEEF_0000_0001);
    finish_load(1'b0, '0);

    repeat (3) @(negedge clk);
    chk("final_wr_queue_empty", 64'(exp_q.size()), 64'(0));
    chk("final_exec_queue_empty", 64'(exp_exec.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
